// File: rtl/pong_core.sv
// rtl/pong_core.sv - two-player Pong engine: tick divider, match FSM, paddles, ball physics, scores, pixel colour
// Optional feature macro PONG_CPU_EN: right paddle tracks the ball instead of p2_up/p2_dn.
module pong_core #(
  parameter int SCR_W       = 96,
  parameter int SCR_H       = 64,
  parameter int PAD_H       = 12,
  parameter int BALL_SZ     = 2,
  parameter int WIN_SCORE   = 7,
  parameter int TICK_DIV    = 1_000_000,
  parameter int PAUSE_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        start,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  input  logic [1:0]  diff,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  output logic [15:0] oled_data,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [2:0]  state,
  output logic [1:0]  winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW    = $clog2(PAUSE_TICKS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PAUSE_LAST = PW'(PAUSE_TICKS - 1);
  localparam logic [6:0] P_MAX = 7'(SCR_H - PAD_H);
  localparam logic [6:0] P_MID = 7'((SCR_H - PAD_H) / 2);
  localparam logic [6:0] BX0   = 7'((SCR_W - BALL_SZ) / 2);
  localparam logic [6:0] BY0   = 7'((SCR_H - BALL_SZ) / 2);
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);
  localparam logic signed [9:0] Y_MAX  = 10'(SCR_H - BALL_SZ);
  localparam logic signed [9:0] X_LIM  = 10'(SCR_W - 3 - BALL_SZ);
  localparam logic signed [9:0] X_MISS = 10'(SCR_W - BALL_SZ);

  localparam logic [15:0] C_GREEN  = 16'h07E0;
  localparam logic [15:0] C_CYAN   = 16'h07FF;
  localparam logic [15:0] C_WHITE  = 16'hFFFF;
  localparam logic [15:0] C_GREY   = 16'h8410;
  localparam logic [15:0] C_YELLOW = 16'hFFE0;

  state_t st;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0] pause;
  logic [6:0] p1_y, p2_y, ball_x, ball_y;
  logic ball_dx, ball_dy, serve_dx;  // dx=1 right, dy=1 down
  logic active, tick;

  assign state  = st;
  assign active = (st == S_SERVE) || (st == S_PLAY) || (st == S_POINT);
  assign tick   = active && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n || !active || cnt == CNT_MAX) cnt <= '0;
    else                                     cnt <= cnt + 1'b1;
  end

  logic p2_mv_up, p2_mv_dn;
`ifdef PONG_CPU_EN
  logic [7:0] ball_mid, pad_mid;
  logic unused_p2;
  assign unused_p2 = p2_up ^ p2_dn;
  assign ball_mid  = {1'b0, ball_y} + 8'(BALL_SZ / 2);
  assign pad_mid   = {1'b0, p2_y} + 8'(PAD_H / 2);
  assign p2_mv_up  = ball_dx && (ball_mid < pad_mid);
  assign p2_mv_dn  = ball_dx && (ball_mid > pad_mid);
`else
  assign p2_mv_up = p2_up;
  assign p2_mv_dn = p2_dn;
`endif

  function automatic logic [6:0] pad_next(input logic [6:0] py, input logic up, input logic dn);
    if (up && !dn && py != 7'd0) return py - 7'd1;
    if (dn && !up && py < P_MAX) return py + 7'd1;
    return py;
  endfunction

  // Ball physics for one PLAY tick; paddle overlap uses the rows the ball occupies before the move.
  logic signed [9:0] step, bx_s, by_s, ny_t, nx_l, nx_r;
  logic [6:0] nx, ny;
  logic ndx, ndy, miss_l, miss_r, ov1, ov2;

  assign step = $signed({8'b0, diff}) + 10'sd1;
  assign bx_s = $signed({3'b0, ball_x});
  assign by_s = $signed({3'b0, ball_y});
  assign ny_t = ball_dy ? by_s + step : by_s - step;
  assign nx_l = bx_s - step;
  assign nx_r = bx_s + step;
  assign ov1  = ({1'b0, ball_y} + 8'(BALL_SZ - 1) >= {1'b0, p1_y}) &&
                ({1'b0, ball_y} <= {1'b0, p1_y} + 8'(PAD_H - 1));
  assign ov2  = ({1'b0, ball_y} + 8'(BALL_SZ - 1) >= {1'b0, p2_y}) &&
                ({1'b0, ball_y} <= {1'b0, p2_y} + 8'(PAD_H - 1));

  always_comb begin
    nx = ball_x; ny = ball_y; ndx = ball_dx; ndy = ball_dy;
    miss_l = 1'b0; miss_r = 1'b0;
    if (ny_t < 0) begin
      ny = 7'd0; ndy = ~ball_dy;
    end else if (ny_t > Y_MAX) begin
      ny = Y_MAX[6:0]; ndy = ~ball_dy;
    end else begin
      ny = ny_t[6:0];
    end
    if (!ball_dx) begin
      if (nx_l <= 10'sd3 && ov1) begin nx = 7'd3; ndx = 1'b1; end
      else if (nx_l <= 10'sd0)   begin nx = 7'd0; miss_l = 1'b1; end
      else                       nx = nx_l[6:0];
    end else begin
      if (nx_r >= X_LIM && ov2)  begin nx = X_LIM[6:0]; ndx = 1'b0; end
      else if (nx_r >= X_MISS)   begin nx = X_MISS[6:0]; miss_r = 1'b1; end
      else                       nx = nx_r[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_IDLE; score1 <= 4'd0; score2 <= 4'd0; winner <= 2'd0; pause <= '0;
      p1_y <= P_MID; p2_y <= P_MID; ball_x <= BX0; ball_y <= BY0;
      ball_dx <= 1'b0; ball_dy <= 1'b0; serve_dx <= 1'b0;
    end else if (!en) begin
      st <= S_IDLE;
    end else begin
      if (tick) begin
        p1_y <= pad_next(p1_y, p1_up, p1_dn);
        p2_y <= pad_next(p2_y, p2_mv_up, p2_mv_dn);
      end
      case (st)
        S_IDLE, S_OVER: if (start) begin
          st <= S_SERVE; score1 <= 4'd0; score2 <= 4'd0; winner <= 2'd0; pause <= '0;
          ball_x <= BX0; ball_y <= BY0; ball_dx <= 1'b0; ball_dy <= 1'b0;
        end
        S_SERVE: if (tick) begin
          if (pause == PAUSE_LAST) begin st <= S_PLAY; pause <= '0; end
          else pause <= pause + 1'b1;
        end
        S_PLAY: if (tick) begin
          ball_x <= nx; ball_y <= ny; ball_dx <= ndx; ball_dy <= ndy;
          if (miss_l || miss_r) begin
            st <= S_POINT; pause <= '0;
            serve_dx <= ball_dx;  // next serve heads toward the player who conceded
            if (miss_l && score2 < WIN) score2 <= score2 + 4'd1;
            if (miss_r && score1 < WIN) score1 <= score1 + 4'd1;
          end
        end
        S_POINT: if (tick) begin
          if (pause == PAUSE_LAST) begin
            pause <= '0;
            if (score1 == WIN || score2 == WIN) begin
              st <= S_OVER; winner <= (score1 == WIN) ? 2'd1 : 2'd2;
            end else begin
              st <= S_SERVE; ball_x <= BX0; ball_y <= BY0; ball_dx <= serve_dx; ball_dy <= 1'b0;
            end
          end else pause <= pause + 1'b1;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  logic in_p1, in_p2, in_ball, in_line;
  assign in_p1   = (x == 7'd1 || x == 7'd2) && (y >= p1_y) && ({1'b0, y} < {1'b0, p1_y} + 8'(PAD_H));
  assign in_p2   = (x == 7'(SCR_W - 3) || x == 7'(SCR_W - 2)) && (y >= p2_y) &&
                   ({1'b0, y} < {1'b0, p2_y} + 8'(PAD_H));
  assign in_ball = (st != S_IDLE) && (x >= ball_x) && ({1'b0, x} < {1'b0, ball_x} + 8'(BALL_SZ)) &&
                   (y >= ball_y) && ({1'b0, y} < {1'b0, ball_y} + 8'(BALL_SZ));
  assign in_line = (x == 7'(SCR_W / 2)) && !y[2];

  always_ff @(posedge clk) begin
    if (!rst_n)       oled_data <= 16'h0000;
    else if (in_p1)   oled_data <= (st == S_OVER && winner == 2'd1) ? C_YELLOW : C_GREEN;
    else if (in_p2)   oled_data <= (st == S_OVER && winner == 2'd2) ? C_YELLOW : C_CYAN;
    else if (in_ball) oled_data <= C_WHITE;
    else if (in_line) oled_data <= C_GREY;
    else              oled_data <= 16'h0000;
  end

endmodule

// File: doc/pong_core.md
# pong_core

Parametrised two-player Pong game engine for the OLED game mode. It owns the frame-tick divider, the match state machine, both paddles, the ball physics, the scores and the per-pixel colour lookup. It generalises the fixed 96x64 single-speed game to configurable screen size, paddle size, win score and speed, and adds serve, point and game-over phases. It sits between the OLED pixel scanner (x, y in; oled_data out) and the 7-segment score display.

## Interface
Parameters:
- SCR_W, 96: screen width in pixels.
- SCR_H, 64: screen height in pixels.
- PAD_H, 12: paddle height in pixels. Paddle width is fixed at 2.
- BALL_SZ, 2: ball edge length in pixels.
- WIN_SCORE, 7: first score reaching this value wins. Range 1–15.
- TICK_DIV, 1_000_000: clk cycles per game tick.
- PAUSE_TICKS, 30: ticks spent in SERVE and in POINT.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous, active-low reset.
- en, input, 1: game mode enable. While en=0 the whole core is held in IDLE.
- start, input, 1: level input. Leaves IDLE/OVER when en=1.
- p1_up, p1_dn, input, 1 each: left-paddle buttons.
- p2_up, p2_dn, input, 1 each: right-paddle buttons. These are ignored when PONG_CPU_EN is defined.
- diff, input, 2: ball speed. The ball moves diff+1 px per axis per tick.
- x, y, input, 7 each: pixel being scanned.
- oled_data, output, 16: RGB565 colour of pixel (x, y). Registered.
- score1, score2, output, 4 each: current scores.
- state, output, 3: FSM state encoding.
- winner, output, 2: 0 = none, 1 = left player, 2 = right player.

## Operation
Tick generation:
- A counter runs from 0 to TICK_DIV-1, then wraps.
- tick is a 1-cycle pulse on the wrap.
- The counter is held at 0 outside PLAY/SERVE/POINT.

FSM states: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- IDLE → SERVE when en & start.
  - On entry to SERVE: scores clear, winner clears, pause counter clears.
  - The ball is centred at ((SCR_W-BALL_SZ)/2, (SCR_H-BALL_SZ)/2).
  - Initial direction is left-up.
- SERVE → PLAY after PAUSE_TICKS ticks. The ball is frozen and paddles move during SERVE.
- PLAY → POINT on a miss.
- POINT → SERVE after PAUSE_TICKS ticks if neither score equals WIN_SCORE. Otherwise POINT → OVER. The pause counter clears on entry to each state.
- OVER → SERVE when start=1; this clears the scores.
- Any state → IDLE on en=0, within 1 cycle. Scores are kept.

Paddles:
- The paddle Y register holds the top row. Reset value is (SCR_H-PAD_H)/2.
- On each tick in SERVE/PLAY/POINT, a paddle moves 1 px: up if up=1, down if dn=1. If both are pressed it does not move.
- Paddle Y is clamped to the range 0..SCR_H-PAD_H.
- The left paddle occupies columns 1–2. The right paddle occupies columns SCR_W-3 to SCR_W-2.

Ball, on each PLAY tick:
- Step s = diff+1.
- Vertical: if the next Y is below 0, Y becomes 0 and dy flips. If the next Y is above SCR_H-BALL_SZ, Y is clamped to that value and dy flips.
- Horizontal, moving left: if the next X is at or below 3 and the ball rows overlap the left paddle rows, X becomes 3 and dx flips. If the next X is at or below 0 without overlap, that is a miss: score2 increments.
- The right side is mirrored. The limit is SCR_W-3-BALL_SZ; a right-side miss increments score1.
- After a point, the next serve goes toward the player who conceded.
- Scores saturate at WIN_SCORE.
- A simultaneous wall bounce and paddle hit in the same tick apply both flips.

Colour priority: left paddle GREEN > right paddle CYAN > ball WHITE > centre dashed line (x == SCR_W/2 and y[2]=0) GREY > BLACK. In OVER, the winner's paddle is drawn YELLOW.

Reset: rst_n=0 at a rising clk edge has the following result:
- state = IDLE
- scores = 0
- winner = 0
- oled_data = 0
- paddles and ball are centred
- tick counter = 0

## Timing
- oled_data is registered from (x, y). It reflects the pixel presented 1 cycle earlier.
- All game state updates on the cycle that tick is high. A score increments on the same cycle as the PLAY → POINT transition.
- score and winner are registered outputs. winner is set on the POINT → OVER cycle.
- Reset asserted mid-game takes effect at the next edge. No partial tick survives.

## Configuration
- PONG_CPU_EN defined: the right paddle is computer-controlled. Each tick it moves 1 px toward the ball's centre row, only while dx points right. p2_up and p2_dn are ignored.
- PONG_CPU_EN undefined: the right paddle is driven by p2_up and p2_dn.

## Test plan
All scenarios use TICK_DIV=4 and PAUSE_TICKS=2.
- Reset: hold rst_n=0 for 3 cycles → state=0, score1=score2=0, oled_data=0. Pixel (48,31) on the next read is WHITE only after leaving IDLE.
- Serve: en=1, start=1 → state=1. After 2 ticks, state=2. The ball moves −(diff+1) in both X and Y per tick.
- Wall bounce: ball at Y=1, dy up, diff=1 → next Y=0 and dy flips. The following tick gives Y=2.
- Paddle hit and miss, left paddle at Y=0, ball moving left:
  - Ball Y=5 → X=3, direction right, no score change.
  - Ball Y=40 → score2=1, state=3.
- Game over, WIN_SCORE=2: two right misses → score1=2, state=4, winner=1, left paddle pixels YELLOW. start=1 → state=1 with scores 0.
- Clamp and disable: hold p1_dn for 60 ticks → paddle Y=SCR_H-PAD_H=52. en=0 mid-PLAY → state=0 the next cycle.
